// File: rtl/alu_div_seq.sv
// alu_div_seq: iterative radix-2 restoring divider feeding the ALU DIV input.
// One quotient bit per clock; DONE is a one-cycle registered pulse.
// Optional macro ALU_DIV_SIGNED_EN: when defined, SIGNED_OP selects two's-
// complement division and the FIX state applies sign correction; otherwise
// every operation is unsigned and FIX is a plain one-cycle load.
//
// state | meaning
// IDLE  | waiting for START, results held
// CALC  | N shift/subtract iterations
// FIX   | sign correction and result load
// FIN   | completion cycle, DONE raised on the following edge
module alu_div_seq #(
    parameter int N = 32
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         SIGNED_OP,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] QUOTIENT,
    output logic [N-1:0] REMAINDER,
    output logic         DIV_BY_ZERO
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   rem_q, dvd_q, dvs_q;
    logic [CW-1:0]  cnt_q;
    logic           done_q;

    logic [N:0]     shifted, diff;
    logic           ge;
    logic [N-1:0]   mag_a, mag_b;
    logic [N-1:0]   q_fix, r_fix;

`ifdef ALU_DIV_SIGNED_EN
    logic sign_a, sign_b;
    logic neg_q_q, neg_r_q;

    // Operand magnitudes and sign-corrected results for two's-complement mode.
    always_comb begin
        sign_a = SIGNED_OP & A[N-1];
        sign_b = SIGNED_OP & B[N-1];
        mag_a  = sign_a ? -A : A;
        mag_b  = sign_b ? -B : B;
        q_fix  = neg_q_q ? -dvd_q : dvd_q;
        r_fix  = neg_r_q ? -rem_q : rem_q;
    end

    // Sign flags captured with the operands on an accepted START.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (state == IDLE && START) begin
            neg_q_q <= sign_a ^ sign_b;
            neg_r_q <= sign_a;
        end
    end
`else
    logic unused_signed_op;

    // Unsigned-only build: operands and results pass straight through.
    always_comb begin
        mag_a            = A;
        mag_b            = B;
        q_fix            = dvd_q;
        r_fix            = rem_q;
        unused_signed_op = SIGNED_OP;
    end
`endif

    // Single N+1-bit subtractor; the top bit is the borrow because rem < divisor.
    always_comb begin
        shifted = {rem_q, dvd_q[N-1]};
        diff    = shifted - {1'b0, dvs_q};
        ge      = ~diff[N];
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and BUSY.
    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        case (state)
            IDLE: if (START) state_nxt = (B == '0) ? FIN : CALC;
            CALC: begin
                BUSY = 1'b1;
                if (cnt_q == '0) state_nxt = FIX;
            end
            FIX: begin
                BUSY      = 1'b1;
                state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            QUOTIENT    <= '0;
            REMAINDER   <= '0;
            DIV_BY_ZERO <= 1'b0;
        end else begin
            done_q <= (state == FIN);
            case (state)
                IDLE: if (START) begin
                    if (B == '0) begin
                        QUOTIENT    <= '1;
                        REMAINDER   <= A;
                        DIV_BY_ZERO <= 1'b1;
                    end else begin
                        rem_q       <= '0;
                        dvd_q       <= mag_a;
                        dvs_q       <= mag_b;
                        cnt_q       <= CNT_INIT;
                        DIV_BY_ZERO <= 1'b0;
                    end
                end
                CALC: begin
                    rem_q <= ge ? diff[N-1:0] : shifted[N-1:0];
                    dvd_q <= {dvd_q[N-2:0], ge};
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                FIX: begin
                    QUOTIENT    <= q_fix;
                    REMAINDER   <= r_fix;
                    DIV_BY_ZERO <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign DONE = done_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq (N=32): directed test-plan vectors,
// handshake corner cases, mid-operation reset and randomized operands, all
// compared against a plain-arithmetic reference model.
module tb_alu_div_seq;

    localparam int N = 32;
`ifdef ALU_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N, START, SIGNED_OP;
    logic [N-1:0]  A, B;
    logic          BUSY, DONE, DIV_BY_ZERO;
    logic [N-1:0]  QUOTIENT, REMAINDER;

    int vectors = 0;
    int miscompares = 0;

    logic [N-1:0] exp_q, exp_r;
    logic         exp_dz;
    int           exp_lat, exp_busy, busy_cnt;

    alu_div_seq #(.N(N)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
        .SIGNED_OP(SIGNED_OP), .BUSY(BUSY), .DONE(DONE),
        .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER), .DIV_BY_ZERO(DIV_BY_ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                                  output logic [N-1:0] q, output logic [N-1:0] r, output logic dz);
        longint sa, sb, qq, rr;
        dz = 1'b0;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (SIGNED_EN && s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[N-1:0];
            r  = rr[N-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called #1 after an edge; START is sampled on the next edge.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        A = a; B = b; SIGNED_OP = s; START = 1'b1;
        model(a, b, s, exp_q, exp_r, exp_dz);
        exp_lat  = (b == 0) ? 1 : N + 2;
        exp_busy = (b == 0) ? 0 : N + 1;
        @(posedge CLK); #1;
        START = 1'b0;
        A = $urandom; B = $urandom; SIGNED_OP = 1'($urandom_range(0, 1));
        chk("busy_after_start", BUSY, (b != 0));
        chk("done_low_after_start", DONE, 0);
        busy_cnt = BUSY ? 1 : 0;
    endtask

    task automatic wait_done(input int poke_at, input bit trail);
        int lat;
        lat = 0;
        for (int k = 1; k <= N + 8; k++) begin
            if (k == poke_at) begin
                START = 1'b1; A = $urandom; B = $urandom | 32'd1;
                SIGNED_OP = 1'($urandom_range(0, 1));
            end else begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
            if (BUSY) busy_cnt++;
            if (DONE) begin
                lat = k;
                break;
            end
        end
        START = 1'b0;
        chk("latency", lat, exp_lat);
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("quotient", QUOTIENT, exp_q);
        chk("remainder", REMAINDER, exp_r);
        chk("div_by_zero", DIV_BY_ZERO, exp_dz);
        if (trail) begin
            @(posedge CLK); #1;
            chk("done_pulse_width", DONE, 0);
            chk("busy_idle", BUSY, 0);
            chk("quotient_held", QUOTIENT, exp_q);
            chk("remainder_held", REMAINDER, exp_r);
        end
    endtask

    logic [N-1:0] da [9] = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'h12345678, 32'h80000000,
                             32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd5};
    logic [N-1:0] db [9] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'd5, 32'd1, 32'hFFFFFFFF};
    logic         ds [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int dones;
        logic [N-1:0] ra, rb;
        RST_N = 1'b0; START = 1'b0; A = '0; B = '0; SIGNED_OP = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_busy", BUSY, 0);
        chk("reset_done", DONE, 0);
        chk("reset_quotient", QUOTIENT, 0);
        chk("reset_remainder", REMAINDER, 0);
        chk("reset_dbz", DIV_BY_ZERO, 0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Test-plan vectors, including divide-by-zero and overflow boundaries.
        for (int i = 0; i < 9; i++) begin
            start_op(da[i], db[i], ds[i]);
            wait_done(0, 1'b1);
        end

        // START during CALC is ignored.
        start_op(32'd1000, 32'd3, 1'b0);
        wait_done(5, 1'b1);
        // START during FIN is ignored.
        start_op(32'd777, 32'd10, 1'b0);
        wait_done(N + 2, 1'b1);

        // Back-to-back: START in the IDLE cycle right after FIN.
        start_op(32'hDEADBEEF, 32'd13, 1'b0);
        wait_done(0, 1'b0);
        start_op(32'hFFFFFF00, 32'd9, 1'b1);
        wait_done(0, 1'b1);

        // Randomized operands.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = $urandom_range(1, 255);
                2:       rb = -$urandom_range(1, 255);
                default: rb = ($urandom_range(0, 1) != 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            start_op(ra, rb, 1'($urandom_range(0, 1)));
            wait_done(0, 1'b1);
        end

        // Reset mid-operation aborts and discards the result.
        start_op(32'hCAFEF00D, 32'd77, 1'b0);
        repeat (10) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        chk("abort_quotient", QUOTIENT, 0);
        chk("abort_remainder", REMAINDER, 0);
        chk("abort_dbz", DIV_BY_ZERO, 0);
        dones = 0;
        for (int k = 0; k < N + 8; k++) begin
            @(posedge CLK); #1;
            if (DONE) dones++;
        end
        chk("abort_no_done", dones, 0);
        start_op(32'd12345, 32'd100, 1'b0);
        wait_done(0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
- Iterative radix-2 restoring divider that produces the DIV operand consumed by the ALU result multiplexer (selector 4'b1010).
- Accepts a dividend/divisor pair on a START pulse and computes one quotient bit per clock.
- Presents quotient and remainder with a single-cycle DONE pulse. Results are held stable until the next accepted START.
- The ALU control holds the result-mux selection until DONE.

Parameters:
N, 32, operand/result width in bits (N >= 4).

Ports:
CLK  input  1  system clock, all logic rising-edge.
RST_N  input  1  synchronous active-low reset, sampled on rising CLK.
START  input  1  request; sampled only when BUSY=0.
A  input  N  dividend, captured on accepted START.
B  input  N  divisor, captured on accepted START.
SIGNED_OP  input  1  1 = two's-complement division, 0 = unsigned; captured with operands.
BUSY  output  1  high from cycle after accepted START until DONE cycle (exclusive).
DONE  output  1  one-cycle pulse: QUOTIENT/REMAINDER valid.
QUOTIENT  output  N  result; wired to the result mux DIV input.
REMAINDER  output  N  remainder.
DIV_BY_ZERO  output  1  valid with DONE; held until next accepted START.

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous and active-low (RST_N).
- Reset values: RST_N=0 at a rising edge forces state IDLE and sets BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0, DIV_BY_ZERO=0. Reset mid-operation aborts the operation and discards it.
- States: IDLE, CALC, FIX, FIN.
- IDLE:
  - START=1 and B!=0: capture magnitudes |A|, |B|, with sign flags when SIGNED_OP=1 (raw values when SIGNED_OP=0). Clear the partial remainder, set bit counter = N-1, go to CALC.
  - START=1 and B==0: go to FIN with QUOTIENT = all ones, REMAINDER = A (unmodified), DIV_BY_ZERO=1.
- CALC (exactly N cycles):
  - Shift {rem, dividend} left by 1.
  - If rem >= divisor: subtract and shift in quotient bit 1, else shift in 0.
  - Use an N+1-bit subtractor.
  - When counter reaches 0, go to FIX; otherwise decrement the counter.
- FIX (1 cycle):
  - If signed and sign(A)^sign(B): negate quotient.
  - If signed and sign(A): negate remainder.
  - Load QUOTIENT/REMAINDER, DIV_BY_ZERO=0, go to FIN.
- FIN (1 cycle): DONE=1, BUSY=0, return to IDLE. DONE is registered.
- Latency:
  - START accepted at edge 0 → DONE high during the cycle after edge N+2.
  - Divide-by-zero: DONE high during the cycle after edge 1.
- BUSY=1 in CALC and FIX only.
- START while BUSY=1 or in FIN is ignored: no queueing, and captured operands are unchanged.
- Back-to-back: START in the cycle following FIN (state IDLE) is accepted normally.
- Signed overflow (A = most negative, B = -1):
  - Magnitude path yields QUOTIENT = most negative value (two's-complement wrap), REMAINDER = 0.
  - DIV_BY_ZERO=0 and no other flag.
- QUOTIENT/REMAINDER change only in FIX, on a divide-by-zero load, or on reset. They are stable in IDLE.
- Magnitude conversion of the most-negative value treats it as unsigned 2^(N-1). This is correct because the datapath is unsigned N-bit.

Optional Feature:
- Macro ALU_DIV_SIGNED_EN.
- Defined: SIGNED_OP is honoured and the FIX-state negation logic is present.
- Undefined:
  - SIGNED_OP is ignored and all operations are unsigned.
  - The FIX state remains as a 1-cycle pass-through, so latency is identical (N+2) in both builds.
  - No negation hardware is synthesized.

Test Plan:
- Unsigned, N=32: A=100, B=7, SIGNED_OP=0 → DONE exactly 34 cycles after START edge, QUOTIENT=14, REMAINDER=2, DIV_BY_ZERO=0, BUSY high 33 cycles.
- Signed (macro defined): A=-100 (0xFFFFFF9C), B=7 → QUOTIENT=-14 (0xFFFFFFF2), REMAINDER=-2 (0xFFFFFFFE). Repeat with A=100, B=-7 → QUOTIENT=-14, REMAINDER=2.
- Divide by zero: A=0x12345678, B=0 → DONE 1 cycle after START, QUOTIENT=0xFFFFFFFF, REMAINDER=0x12345678, DIV_BY_ZERO=1.
- Overflow/boundary:
  - A=0x80000000, B=0xFFFFFFFF, signed → QUOTIENT=0x80000000, REMAINDER=0.
  - Same operands unsigned → QUOTIENT=0, REMAINDER=0x80000000.
- Handshake:
  - Pulse START again mid-CALC with different operands → ignored, first result unchanged.
  - START in the IDLE cycle right after FIN → accepted, second DONE N+2 cycles later.
- Reset mid-operation: drive RST_N=0 for 1 cycle at CALC cycle 10 → next cycle BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0. No DONE follows; a new START completes normally.
